// File: rtl/nco_sweep_ctrl.sv
// NCO step-frequency sweep controller driving dsm_core nco_step/nco_step_enable; optional NCO_SWEEP_TRIANGLE_EN.
// Latency: start accepted in IDLE shows nco_step=f_start and busy one cycle later; each step lasts dwell_cycles+2.
// Backpressure: none; start is ignored while busy, abort and rst win on the next edge.
module nco_sweep_ctrl #(
  parameter int ACC_FRAC_WIDTH = 24,
  parameter int ACC_INT_WIDTH  = 8,
  parameter int DWELL_WIDTH    = 16,
  localparam int SW            = ACC_FRAC_WIDTH + ACC_INT_WIDTH
) (
  input  logic                   aclk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [SW-1:0]          f_start,
  input  logic [SW-1:0]          f_stop,
  input  logic [SW-1:0]          f_incr,
  input  logic [DWELL_WIDTH-1:0] dwell_cycles,
  input  logic                   loop_en,
  output logic [SW-1:0]          nco_step,
  output logic                   nco_step_enable,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DWELL,
    ST_ADVANCE,
    ST_FINISH
  } state_t;

  state_t state, state_nxt;

  logic [SW-1:0]          cfg_start;
  logic [SW-1:0]          cfg_stop;
  logic [SW-1:0]          cfg_incr;
  logic [DWELL_WIDTH-1:0] cfg_dwell;
  logic                   cfg_loop;
  logic                   dir_up;
  logic [DWELL_WIDTH-1:0] dwell_cnt;

  logic                   sweep_end;
  logic                   dwell_last;
  logic                   step_up;
  logic [SW-1:0]          step_lim;
  logic [SW:0]            step_sum;
  logic [SW:0]            step_dif;
  logic [SW-1:0]          step_next;

  assign sweep_end  = (nco_step == cfg_stop) || (cfg_incr == '0);
  assign dwell_last = (dwell_cnt == cfg_dwell);

`ifdef NCO_SWEEP_TRIANGLE_EN
  // At the turn, step away from the old stop toward the old start so the apex is not repeated.
  assign step_up  = sweep_end ? ~dir_up : dir_up;
  assign step_lim = sweep_end ? cfg_start : cfg_stop;
`else
  assign step_up  = dir_up;
  assign step_lim = cfg_stop;
`endif

  // One extra bit catches carry-out / borrow so the clamp never lets the step wrap.
  always_comb begin
    step_sum = {1'b0, nco_step} + {1'b0, cfg_incr};
    step_dif = {1'b0, nco_step} - {1'b0, cfg_incr};
    if (step_up) begin
      step_next = (step_sum[SW] || (step_sum[SW-1:0] > step_lim)) ? step_lim : step_sum[SW-1:0];
    end else begin
      step_next = (step_dif[SW] || (step_dif[SW-1:0] < step_lim)) ? step_lim : step_dif[SW-1:0];
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state_nxt = ST_DWELL;
        end
        ST_DWELL: begin
          if (dwell_last) state_nxt = ST_ADVANCE;
        end
        ST_ADVANCE: begin
          if (sweep_end && !cfg_loop) state_nxt = ST_FINISH;
          else                        state_nxt = ST_DWELL;
        end
        ST_FINISH: begin
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_DWELL, ST_ADVANCE: busy = 1'b1;
      ST_FINISH:            done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      nco_step        <= '0;
      nco_step_enable <= 1'b0;
      dwell_cnt       <= '0;
      cfg_start       <= '0;
      cfg_stop        <= '0;
      cfg_incr        <= '0;
      cfg_dwell       <= '0;
      cfg_loop        <= 1'b0;
      dir_up          <= 1'b0;
    end else if (abort) begin
      nco_step_enable <= 1'b0;
      dwell_cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cfg_start       <= f_start;
            cfg_stop        <= f_stop;
            cfg_incr        <= f_incr;
            cfg_dwell       <= dwell_cycles;
            cfg_loop        <= loop_en;
            dir_up          <= (f_stop >= f_start);
            nco_step        <= f_start;
            nco_step_enable <= 1'b1;
            dwell_cnt       <= '0;
          end
        end
        ST_DWELL: begin
          if (!dwell_last) dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
        end
        ST_ADVANCE: begin
          dwell_cnt <= '0;
          if (!sweep_end) begin
            nco_step <= step_next;
          end else if (cfg_loop) begin
`ifdef NCO_SWEEP_TRIANGLE_EN
            cfg_start <= cfg_stop;
            cfg_stop  <= cfg_start;
            dir_up    <= ~dir_up;
            nco_step  <= step_next;
`else
            nco_step  <= cfg_start;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed-vector bench for nco_sweep_ctrl; expected step sequences are hand-computed.
module tb_nco_sweep_ctrl;

  logic        aclk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] f_start;
  logic [31:0] f_stop;
  logic [31:0] f_incr;
  logic [15:0] dwell_cycles;
  logic        loop_en;
  logic [31:0] nco_step;
  logic        nco_step_enable;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] seen_val[32];
  int          seen_len[32];
  int          seen_first[32];
  int          n_seen;
  int          done_cnt;
  int          done_at;

  nco_sweep_ctrl #(
    .ACC_FRAC_WIDTH(24),
    .ACC_INT_WIDTH (8),
    .DWELL_WIDTH   (16)
  ) dut (
    .aclk           (aclk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .f_start        (f_start),
    .f_stop         (f_stop),
    .f_incr         (f_incr),
    .dwell_cycles   (dwell_cycles),
    .loop_en        (loop_en),
    .nco_step       (nco_step),
    .nco_step_enable(nco_step_enable),
    .busy           (busy),
    .done           (done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic setup(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] fi,
                       input logic [15:0] dw, input logic lp);
    f_start      = fs;
    f_stop       = fe;
    f_incr       = fi;
    dwell_cycles = dw;
    loop_en      = lp;
  endtask

  // One idle cycle first so a preceding FINISH has returned to IDLE.
  task automatic do_start();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic collect(input int max_cycles, input bit stop_on_done);
    n_seen   = 0;
    done_cnt = 0;
    done_at  = -1;
    for (int c = 0; c < max_cycles; c++) begin
      if (done) begin
        done_cnt++;
        done_at = c;
        if (stop_on_done) break;
      end else if (busy) begin
        if (n_seen == 0 || nco_step != seen_val[n_seen-1]) begin
          if (n_seen < 32) begin
            seen_val[n_seen]   = nco_step;
            seen_len[n_seen]   = 1;
            seen_first[n_seen] = c;
            n_seen++;
          end
        end else begin
          seen_len[n_seen-1]++;
        end
      end
      tick();
    end
  endtask

  initial begin
    logic [31:0] exp_v[7];
    bit          bad;

    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    setup(32'h0, 32'h0, 32'h0, 16'h0, 1'b0);
    tick();
    tick();
    chk("rst_step",   nco_step, 0);
    chk("rst_enable", nco_step_enable, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_done",   done, 0);
    rst = 1'b0;

    // Basic up sweep, dwell 2: four values, 4 cycles each, last one dwells 3 before done.
    setup(32'h0100_0000, 32'h0400_0000, 32'h0100_0000, 16'd2, 1'b0);
    do_start();
    chk("basic_first_busy", busy, 1);
    collect(200, 1);
    chk("basic_nvals", n_seen, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("basic_val%0d", i), seen_val[i], (i + 1) << 24);
    for (int i = 0; i < 3; i++) chk($sformatf("basic_len%0d", i), seen_len[i], 4);
    chk("basic_last_dwell", done_at - seen_first[3] - 1, 3);
    chk("basic_done",       done_cnt, 1);
    chk("basic_busy_at_done",   busy, 0);
    chk("basic_enable_at_done", nco_step_enable, 1);
    chk("basic_step_at_done",   nco_step, 32'h0400_0000);
    tick();
    chk("basic_done_pulse", done, 0);
    tick();
    chk("basic_idle_enable", nco_step_enable, 1);
    chk("basic_idle_step",   nco_step, 32'h0400_0000);

    // Up overshoot clamps to f_stop.
    setup(32'h10, 32'h25, 32'h10, 16'd0, 1'b0);
    do_start();
    collect(100, 1);
    chk("clamp_nvals", n_seen, 3);
    chk("clamp_v0", seen_val[0], 32'h10);
    chk("clamp_v1", seen_val[1], 32'h20);
    chk("clamp_v2", seen_val[2], 32'h25);
    chk("clamp_len0", seen_len[0], 2);
    chk("clamp_done", done_cnt, 1);

    // Down sweep with undershoot clamp.
    setup(32'h30, 32'h05, 32'h10, 16'd0, 1'b0);
    do_start();
    collect(100, 1);
    chk("down_nvals", n_seen, 4);
    chk("down_v0", seen_val[0], 32'h30);
    chk("down_v1", seen_val[1], 32'h20);
    chk("down_v2", seen_val[2], 32'h10);
    chk("down_v3", seen_val[3], 32'h05);
    chk("down_done", done_cnt, 1);

    // Carry-out near the top of the range must clamp, never wrap.
    setup(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 16'd0, 1'b0);
    do_start();
    collect(100, 1);
    chk("ovf_nvals", n_seen, 3);
    chk("ovf_v0", seen_val[0], 32'hFFFF_FF00);
    chk("ovf_v1", seen_val[1], 32'hFFFF_FF80);
    chk("ovf_v2", seen_val[2], 32'hFFFF_FFFF);
    chk("ovf_done", done_cnt, 1);
    tick();
    tick();
    chk("ovf_hold", nco_step, 32'hFFFF_FFFF);

    // f_start == f_stop: one dwell (2 cycles) plus advance, then done.
    setup(32'h42, 32'h42, 32'h10, 16'd1, 1'b0);
    do_start();
    collect(100, 1);
    chk("eq_nvals", n_seen, 1);
    chk("eq_v0", seen_val[0], 32'h42);
    chk("eq_done_at", done_at, 3);

    // Start while busy is ignored; abort+start at 0x20 goes idle with no done.
    setup(32'h10, 32'h40, 32'h10, 16'd3, 1'b0);
    do_start();
    setup(32'h99, 32'h99, 32'h1, 16'd0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_step", nco_step, 32'h10);
    chk("busy_start_busy", busy, 1);
    for (int c = 0; c < 50 && nco_step != 32'h20; c++) tick();
    chk("abort_reach_20", nco_step, 32'h20);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy",   busy, 0);
    chk("abort_enable", nco_step_enable, 0);
    chk("abort_step",   nco_step, 32'h20);
    chk("abort_done",   done, 0);
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done || busy || nco_step_enable) bad = 1'b1;
    end
    chk("abort_stays_idle", bad, 0);

    // Repeat mode: sawtooth by default, triangle with the macro.
    setup(32'h0, 32'h20, 32'h10, 16'd0, 1'b1);
`ifdef NCO_SWEEP_TRIANGLE_EN
    exp_v = '{32'h0, 32'h10, 32'h20, 32'h10, 32'h0, 32'h10, 32'h20};
`else
    exp_v = '{32'h0, 32'h10, 32'h20, 32'h0, 32'h10, 32'h20, 32'h0};
`endif
    do_start();
    collect(14, 0);
    chk("loop_nvals", n_seen, 7);
    for (int i = 0; i < 7; i++) chk($sformatf("loop_v%0d", i), seen_val[i], exp_v[i]);
    chk("loop_no_done", done_cnt, 0);
    chk("loop_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Reset in DWELL clears everything; a following start behaves normally.
    setup(32'h50, 32'h90, 32'h10, 16'd5, 1'b0);
    do_start();
    tick();
    tick();
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    chk("mrst_step",   nco_step, 0);
    chk("mrst_enable", nco_step_enable, 0);
    chk("mrst_busy",   busy, 0);
    chk("mrst_done",   done, 0);
    setup(32'h77, 32'h80, 32'h1, 16'd0, 1'b0);
    do_start();
    chk("rstart_step",   nco_step, 32'h77);
    chk("rstart_busy",   busy, 1);
    chk("rstart_enable", nco_step_enable, 1);
    chk("rstart_done",   done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
